// File: rtl/mdu_pkg.sv
// Shared execute-stage constants: MDU operation encodings (funct3 values) and decode helpers.
package mdu_pkg;

  localparam int ARGS_WIDTH = 4;
  typedef logic [ARGS_WIDTH-1:0] args_t;

  localparam args_t MDU_TYPE_MUL    = args_t'(0);
  localparam args_t MDU_TYPE_MULH   = args_t'(1);
  localparam args_t MDU_TYPE_MULHSU = args_t'(2);
  localparam args_t MDU_TYPE_MULHU  = args_t'(3);
  localparam args_t MDU_TYPE_DIV    = args_t'(4);
  localparam args_t MDU_TYPE_DIVU   = args_t'(5);
  localparam args_t MDU_TYPE_REM    = args_t'(6);
  localparam args_t MDU_TYPE_REMU   = args_t'(7);

  function automatic logic mdu_known(args_t t);
    return t <= MDU_TYPE_REMU;
  endfunction

  function automatic logic mdu_is_div(args_t t);
    return (t >= MDU_TYPE_DIV) && (t <= MDU_TYPE_REMU);
  endfunction

  function automatic logic mdu_is_rem(args_t t);
    return (t == MDU_TYPE_REM) || (t == MDU_TYPE_REMU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mdu_if #(parameter int DATA_WIDTH = 32);
  import mdu_pkg::*;

  logic                  i_mdu_valid;
  logic                  o_mdu_ready;
  args_t                 i_mdu_type;
  logic [DATA_WIDTH-1:0] i_mdu_rs1_data;
  logic [DATA_WIDTH-1:0] i_mdu_rs2_data;
  logic                  i_mdu_flush;
  logic                  o_mdu_res_valid;
  logic                  i_mdu_res_ready;
  logic [DATA_WIDTH-1:0] o_mdu_res;

  modport slave (
    input  i_mdu_valid, i_mdu_type, i_mdu_rs1_data, i_mdu_rs2_data,
           i_mdu_flush, i_mdu_res_ready,
    output o_mdu_ready, o_mdu_res_valid, o_mdu_res
  );

  modport master (
    output i_mdu_valid, i_mdu_type, i_mdu_rs1_data, i_mdu_rs2_data,
           i_mdu_flush, i_mdu_res_ready,
    input  o_mdu_ready, o_mdu_res_valid, o_mdu_res
  );

endinterface

// File: rtl/mdu_ctrl.sv
// Sequencer for the iterative MDU: state, step counter, and load/step/fix strobes.
module mdu_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_flush,
  input  logic i_special,
  input  logic i_res_ready,
  output logic o_ready,
  output logic o_res_valid,
  output logic o_load,
  output logic o_step,
  output logic o_fix
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_ready     = (state_q == S_IDLE);
  assign o_res_valid = (state_q == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_load  = 1'b0;
    o_step  = 1'b0;
    o_fix   = 1'b0;
    // Flush overrides everything, including a same-edge request.
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_valid) begin
          o_load  = 1'b1;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
          // Special cases already have their result; FIX only burns one cycle.
          state_d = i_special ? S_FIX : S_CALC;
        end
        S_CALC: begin
          o_step = 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          o_fix   = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: if (i_res_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, sharing a 2*DATA_WIDTH working register.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic  i_clk,
  input logic  i_rst_n,
  mdu_if.slave bus
);

  localparam int W = DATA_WIDTH;

  logic load, step, fix, special;

  args_t          type_q, type_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   res_q, res_d;
  logic           neg_q, neg_d;
  logic           spec_q, spec_d;

  mdu_ctrl #(.DATA_WIDTH(W)) u_ctrl (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (bus.i_mdu_valid),
    .i_flush     (bus.i_mdu_flush),
    .i_special   (special),
    .i_res_ready (bus.i_mdu_res_ready),
    .o_ready     (bus.o_mdu_ready),
    .o_res_valid (bus.o_mdu_res_valid),
    .o_load      (load),
    .o_step      (step),
    .o_fix       (fix)
  );

  assign bus.o_mdu_res = res_q;

  // Accept-time decode: magnitudes, result sign and special cases.
  args_t        in_type;
  logic [W-1:0] rs1, rs2, a_mag, b_mag, spec_res;
  logic         rs1_sgn, rs2_sgn, rs1_neg, rs2_neg, res_neg, div0, ovf;

  assign in_type = bus.i_mdu_type;
  assign rs1     = bus.i_mdu_rs1_data;
  assign rs2     = bus.i_mdu_rs2_data;
  assign rs1_sgn = (in_type == MDU_TYPE_MUL) || (in_type == MDU_TYPE_MULH) ||
                   (in_type == MDU_TYPE_MULHSU) || (in_type == MDU_TYPE_DIV) ||
                   (in_type == MDU_TYPE_REM);
  assign rs2_sgn = (in_type == MDU_TYPE_MUL) || (in_type == MDU_TYPE_MULH) ||
                   (in_type == MDU_TYPE_DIV) || (in_type == MDU_TYPE_REM);
  assign rs1_neg = rs1_sgn & rs1[W-1];
  assign rs2_neg = rs2_sgn & rs2[W-1];
  assign a_mag   = rs1_neg ? -rs1 : rs1;
  assign b_mag   = rs2_neg ? -rs2 : rs2;
  assign div0    = mdu_is_div(in_type) && (rs2 == '0);
  assign ovf     = ((in_type == MDU_TYPE_DIV) || (in_type == MDU_TYPE_REM)) &&
                   (rs1 == {1'b1, {(W-1){1'b0}}}) && (&rs2);
  assign special = !mdu_known(in_type) || div0 || ovf;

  always_comb begin
    res_neg = 1'b0;
    unique case (in_type)
      MDU_TYPE_MUL, MDU_TYPE_MULH, MDU_TYPE_DIV: res_neg = rs1_neg ^ rs2_neg;
      MDU_TYPE_MULHSU, MDU_TYPE_REM:             res_neg = rs1_neg;
      default:                                   res_neg = 1'b0;
    endcase
  end

  always_comb begin
    spec_res = '0;
    if (!mdu_known(in_type))  spec_res = '0;
    else if (div0)            spec_res = mdu_is_rem(in_type) ? rs1 : '1;
    else if (ovf)             spec_res = mdu_is_rem(in_type) ? '0 : rs1;
  end

  // Per-step arithmetic on the shared working register.
  logic [W:0]     mul_sum, div_sh, div_trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_sel, div_val;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_trial = div_sh - {1'b0, opnd_q};
  assign prod      = neg_q ? -acc_q : acc_q;
  assign div_sel   = mdu_is_rem(type_q) ? acc_q[2*W-1:W] : acc_q[W-1:0];
  assign div_val   = neg_q ? -div_sel : div_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      type_q <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
    end else begin
      type_q <= type_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      spec_q <= spec_d;
    end
  end

  always_comb begin
    type_d = type_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    res_d  = res_q;
    neg_d  = neg_q;
    spec_d = spec_q;
    if (load) begin
      type_d = in_type;
      neg_d  = res_neg;
      spec_d = special;
      if (special) begin
        res_d = spec_res;
      end else if (mdu_is_div(in_type)) begin
        // Dividend shifts out of the low half while quotient bits shift in.
        acc_d  = {{W{1'b0}}, a_mag};
        opnd_d = b_mag;
      end else begin
        acc_d  = {{W{1'b0}}, b_mag};
        opnd_d = a_mag;
      end
    end else if (step) begin
      if (mdu_is_div(type_q)) begin
        if (div_trial[W]) acc_d = {div_sh[W-1:0],    acc_q[W-2:0], 1'b0};
        else              acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end
    end else if (fix && !spec_q) begin
      if (mdu_is_div(type_q))          res_d = div_val;
      else if (type_q == MDU_TYPE_MUL) res_d = prod[W-1:0];
      else                             res_d = prod[2*W-1:W];
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed + scoreboard bench for the iterative MDU (RV32 configuration).
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.DATA_WIDTH(32)) bus ();
  mdu #(.DATA_WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input args_t t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    longint q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    q  = 0;
    case (t)
      MDU_TYPE_MUL:    begin p = sa * sb; return p[31:0];  end
      MDU_TYPE_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_TYPE_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_TYPE_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_TYPE_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = $signed(sa) / $signed(sb);
        return q[31:0];
      end
      MDU_TYPE_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MDU_TYPE_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(sa) % $signed(sb);
        return q[31:0];
      end
      MDU_TYPE_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input args_t t, input logic [31:0] a, input logic [31:0] b);
    if (t > MDU_TYPE_REMU) return 1;
    if (t >= MDU_TYPE_DIV && b == 32'd0) return 1;
    if ((t == MDU_TYPE_DIV || t == MDU_TYPE_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called #1 after a posedge; returns #1 after the edge where the result is seen valid.
  task automatic issue_wait(input string tag, input args_t t, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    logic rdy_seen;
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.i_mdu_type = t;
    bus.i_mdu_rs1_data = a;
    bus.i_mdu_rs2_data = b;
    bus.i_mdu_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    while (!bus.o_mdu_res_valid && n < 100) begin
      if (bus.o_mdu_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " ready_busy"}, 64'(rdy_seen), 64'd0);
    check({tag, " result"}, 64'(bus.o_mdu_res), 64'(e));
  endtask

  task automatic retire(input string tag);
    bus.i_mdu_res_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_res_ready = 1'b0;
    check({tag, " idle_after"}, {62'd0, bus.o_mdu_ready, bus.o_mdu_res_valid}, 64'd2);
  endtask

  task automatic do_op(input string tag, input args_t t, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue_wait(tag, t, a, b, exp, lat);
    retire(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    args_t rt;
    bus.i_mdu_valid = 1'b0;
    bus.i_mdu_type = '0;
    bus.i_mdu_rs1_data = '0;
    bus.i_mdu_rs2_data = '0;
    bus.i_mdu_flush = 1'b0;
    bus.i_mdu_res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.o_mdu_ready), 64'd1);
    check("reset valid", 64'(bus.o_mdu_res_valid), 64'd0);
    check("reset res", 64'(bus.o_mdu_res), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul",    MDU_TYPE_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulh",   MDU_TYPE_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("mulhu",  MDU_TYPE_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulhsu", MDU_TYPE_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("div",    MDU_TYPE_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("rem",    MDU_TYPE_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("divu",   MDU_TYPE_DIVU,   32'd100,       32'd7,         32'd14,        33);
    do_op("remu",   MDU_TYPE_REMU,   32'd100,       32'd7,         32'd2,         33);
    do_op("divu0",  MDU_TYPE_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("remu0",  MDU_TYPE_REMU,   32'd5,         32'd0,         32'd5,         1);
    do_op("div0",   MDU_TYPE_DIV,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1);
    do_op("divovf", MDU_TYPE_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("removf", MDU_TYPE_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    do_op("unknown", args_t'(9),     32'd12,        32'd34,        32'd0,         1);

    for (int i = 0; i < 8; i++) begin
      rt = args_t'(i);
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
      do_op($sformatf("rand%0d", i), rt, ra, rb, ref_mdu(rt, ra, rb), lat_of(rt, ra, rb));
    end

    // Backpressure: result held while consumer stalls; input changes ignored.
    issue_wait("bp", MDU_TYPE_DIVU, 32'd100, 32'd7, 32'd14, 33);
    for (int i = 0; i < 5; i++) begin
      bus.i_mdu_rs1_data = $urandom;
      bus.i_mdu_rs2_data = $urandom;
      bus.i_mdu_type = MDU_TYPE_MUL;
      @(posedge clk); #1;
      check($sformatf("bp hold%0d", i), {31'd0, bus.o_mdu_res_valid, bus.o_mdu_res}, {31'd0, 1'b1, 32'd14});
    end
    retire("bp");

    // Flush at CALC cycle 10.
    bus.i_mdu_type = MDU_TYPE_MUL;
    bus.i_mdu_rs1_data = 32'd3;
    bus.i_mdu_rs2_data = 32'd5;
    bus.i_mdu_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush pre busy", 64'(bus.o_mdu_ready), 64'd0);
    bus.i_mdu_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_flush = 1'b0;
    check("flush idle", {62'd0, bus.o_mdu_ready, bus.o_mdu_res_valid}, 64'd2);
    repeat (40) @(posedge clk);
    #1;
    check("flush no result", 64'(bus.o_mdu_res_valid), 64'd0);
    do_op("post_flush", MDU_TYPE_MUL, 32'd1234, 32'd5678, 32'd7006652, 33);

    // Same-edge request and flush: nothing is accepted.
    bus.i_mdu_type = MDU_TYPE_DIVU;
    bus.i_mdu_rs1_data = 32'd9;
    bus.i_mdu_rs2_data = 32'd0;
    bus.i_mdu_valid = 1'b1;
    bus.i_mdu_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    bus.i_mdu_flush = 1'b0;
    @(posedge clk); #1;
    check("flush_vs_valid", {62'd0, bus.o_mdu_ready, bus.o_mdu_res_valid}, 64'd2);

    // Asynchronous reset mid-CALC; res still holds the previous nonzero result.
    bus.i_mdu_type = MDU_TYPE_DIVU;
    bus.i_mdu_rs1_data = 32'd1000;
    bus.i_mdu_rs2_data = 32'd3;
    bus.i_mdu_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_mdu_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst outputs", {31'd0, bus.o_mdu_ready, bus.o_mdu_res_valid, bus.o_mdu_res}, {31'd0, 1'b1, 1'b0, 32'd0});
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_reset", MDU_TYPE_REMU, 32'd1000, 32'd3, 32'd1, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
